// File: rtl/picorv_pkg.sv
// Shared widths and FSM state types for the PicoRV32 AXI-Lite memory slave.
package picorv_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = 4;
  localparam int LAT_W       = 4;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

endpackage

// File: rtl/picorv_mem_1r1w.sv
// Word-addressed storage: byte-enabled synchronous write, registered synchronous read.
// The array itself is never reset; only the read data register is.
module picorv_mem_1r1w
  import picorv_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       waddr_i,
  input  logic [AXIL_DATA_W-1:0] wdata_i,
  input  logic [AXIL_STRB_W-1:0] wstrb_i,
  input  logic                   re_i,
  input  logic [IDX_W-1:0]       raddr_i,
  output logic [AXIL_DATA_W-1:0] rdata_o
);

  logic [AXIL_DATA_W-1:0] mem [WORDS];
  logic [AXIL_DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < AXIL_STRB_W; b++) begin
        if (wstrb_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Same-edge read of a word being written returns the old contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/picorv_axil_mem.sv
// AXI-Lite slave memory behind picorv32_axi: independent read and write FSMs
// with programmable response latency and handshake counters.
//
// state  | meaning
// W_IDLE | accepting AW and W, in either order
// W_WAIT | latency down-count; commit to array when count reaches zero
// W_RESP | bvalid held until bready
// R_IDLE | arready high, waiting for AR
// R_WAIT | latency down-count; sample array when count reaches zero
// R_RESP | rvalid held with stable rdata until rready
module picorv_axil_mem
  import picorv_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   mem_axi_awvalid,
  output logic                   mem_axi_awready,
  input  logic [AXIL_ADDR_W-1:0] mem_axi_awaddr,
  input  logic [2:0]             mem_axi_awprot,
  input  logic                   mem_axi_wvalid,
  output logic                   mem_axi_wready,
  input  logic [AXIL_DATA_W-1:0] mem_axi_wdata,
  input  logic [AXIL_STRB_W-1:0] mem_axi_wstrb,
  output logic                   mem_axi_bvalid,
  input  logic                   mem_axi_bready,
  input  logic                   mem_axi_arvalid,
  output logic                   mem_axi_arready,
  input  logic [AXIL_ADDR_W-1:0] mem_axi_araddr,
  input  logic [2:0]             mem_axi_arprot,
  output logic                   mem_axi_rvalid,
  input  logic                   mem_axi_rready,
  output logic [AXIL_DATA_W-1:0] mem_axi_rdata,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [LAT_W-1:0] WR_LAT_M1 = LAT_W'(WR_LATENCY - 1);
  localparam logic [LAT_W-1:0] RD_LAT_M1 = LAT_W'(RD_LATENCY - 1);

  wr_state_e              wr_state_q, wr_state_d;
  logic                   aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
  logic [IDX_W-1:0]       waddr_q, waddr_d;
  logic [AXIL_DATA_W-1:0] wdata_q, wdata_d;
  logic [AXIL_STRB_W-1:0] wstrb_q, wstrb_d;
  logic [LAT_W-1:0]       wcnt_q, wcnt_d;
  logic [31:0]            wr_count_q, wr_count_d;
  logic                   mem_we;

  rd_state_e              rd_state_q, rd_state_d;
  logic [IDX_W-1:0]       raddr_q, raddr_d;
  logic [LAT_W-1:0]       rcnt_q, rcnt_d;
  logic [31:0]            rd_count_q, rd_count_d;
  logic                   mem_re;

  logic aw_hs, w_hs, ar_hs;
  logic unused_bits;

  assign aw_hs = mem_axi_awvalid && mem_axi_awready;
  assign w_hs  = mem_axi_wvalid  && mem_axi_wready;
  assign ar_hs = mem_axi_arvalid && mem_axi_arready;

  // Address bits outside the word index are dropped, so high addresses alias.
  assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot,
                         mem_axi_awaddr[1:0], mem_axi_awaddr[AXIL_ADDR_W-1:IDX_W+2],
                         mem_axi_araddr[1:0], mem_axi_araddr[AXIL_ADDR_W-1:IDX_W+2]};

  // ---------------- write path ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state_q <= W_IDLE;
      aw_cap_q   <= 1'b0;
      w_cap_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wcnt_q     <= '0;
      wr_count_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_cap_q   <= aw_cap_d;
      w_cap_q    <= w_cap_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wcnt_q     <= wcnt_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    aw_cap_d   = aw_cap_q;
    w_cap_d    = w_cap_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wcnt_d     = wcnt_q;
    wr_count_d = wr_count_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_cap_d = 1'b1;
          waddr_d  = mem_axi_awaddr[IDX_W+1:2];
        end
        if (w_hs) begin
          w_cap_d = 1'b1;
          wdata_d = mem_axi_wdata;
          wstrb_d = mem_axi_wstrb;
        end
        if ((aw_cap_q || aw_hs) && (w_cap_q || w_hs)) begin
          wr_state_d = W_WAIT;
          wcnt_d     = WR_LAT_M1;
          aw_cap_d   = 1'b0;
          w_cap_d    = 1'b0;
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) wr_state_d = W_RESP;
        else              wcnt_d     = wcnt_q - 1'b1;
      end
      W_RESP: begin
        if (mem_axi_bready) begin
          wr_state_d = W_IDLE;
          wr_count_d = wr_count_q + 32'd1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    mem_axi_awready = (wr_state_q == W_IDLE) && !aw_cap_q;
    mem_axi_wready  = (wr_state_q == W_IDLE) && !w_cap_q;
    mem_axi_bvalid  = (wr_state_q == W_RESP);
    mem_we          = (wr_state_q == W_WAIT) && (wcnt_q == '0);
  end

  // ---------------- read path ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      raddr_q    <= '0;
      rcnt_q     <= '0;
      rd_count_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      raddr_q    <= raddr_d;
      rcnt_q     <= rcnt_d;
      rd_count_q <= rd_count_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    raddr_d    = raddr_q;
    rcnt_d     = rcnt_q;
    rd_count_d = rd_count_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_WAIT;
          raddr_d    = mem_axi_araddr[IDX_W+1:2];
          rcnt_d     = RD_LAT_M1;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) rd_state_d = R_RESP;
        else              rcnt_d     = rcnt_q - 1'b1;
      end
      R_RESP: begin
        if (mem_axi_rready) begin
          rd_state_d = R_IDLE;
          rd_count_d = rd_count_q + 32'd1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    mem_axi_arready = (rd_state_q == R_IDLE);
    mem_axi_rvalid  = (rd_state_q == R_RESP);
    mem_re          = (rd_state_q == R_WAIT) && (rcnt_q == '0);
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

  picorv_mem_1r1w #(
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .we_i    (mem_we),
    .waddr_i (waddr_q),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .re_i    (mem_re),
    .raddr_i (raddr_q),
    .rdata_o (mem_axi_rdata)
  );

endmodule

// File: tb/tb_picorv_axil_mem.sv
// Randomized self-checking bench for picorv_axil_mem against a word-array model.
module tb_picorv_axil_mem;

  localparam int MEM_WORDS = 1024;
  localparam int RD_LAT    = 2;
  localparam int WR_LAT    = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
  logic [3:0]  wstrb = 0;
  logic [2:0]  awprot = 0, arprot = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] rdata, rd_count, wr_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [MEM_WORDS];
  logic [31:0] exp_rd = 0, exp_wr = 0;

  picorv_axil_mem #(.MEM_WORDS(MEM_WORDS), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MEM_WORDS);
  endfunction

  task automatic preload(input int i, input logic [31:0] v);
    dut.u_mem.mem[i] = v;
    model[i] = v;
  endtask

  task automatic apply_reset();
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    resetn = 0;
    repeat (3) tick();
    resetn = 1;
    tick();
    exp_rd = 0; exp_wr = 0;
  endtask

  // order: 0 = AW and W together, 1 = AW first, 2 = W first
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int order, input int bdelay, output int lat, output bit hold_ok);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = (order != 2); wvalid = (order != 1);
    lat = -1; hold_ok = 0;
    while (!(aw_done && w_done) && n < 50) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick(); n++;
      if (hs_aw) begin aw_done = 1; awvalid = 0; end
      if (hs_w)  begin w_done = 1;  wvalid = 0;  end
      if (!aw_done && !awvalid) awvalid = 1;
      if (!w_done && !wvalid) wvalid = 1;
    end
    awvalid = 0; wvalid = 0;
    if (!(aw_done && w_done)) return;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) return;
    lat = n; hold_ok = 1;
    repeat (bdelay) begin tick(); if (!bvalid) hold_ok = 0; end
    bready = 1; tick(); bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdelay,
                          output logic [31:0] d, output int lat, output bit hold_ok);
    bit hs = 0;
    int n = 0;
    araddr = a; arvalid = 1;
    d = '0; lat = -1; hold_ok = 0;
    while (!hs && n < 50) begin hs = arready; tick(); n++; end
    arvalid = 0;
    if (!hs) return;
    rready = (rdelay == 0);
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    if (!rvalid) begin rready = 0; return; end
    lat = n; d = rdata; hold_ok = 1;
    repeat (rdelay) begin
      tick();
      if (!rvalid || rdata !== d || arready) hold_ok = 0;
    end
    rready = 1; tick(); rready = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (awready !== 1'b1) begin errors++; $display("FAIL reset_awready got=%b exp=1", awready); end
    checks++; if (wready !== 1'b1)  begin errors++; $display("FAIL reset_wready got=%b exp=1", wready); end
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready got=%b exp=1", arready); end
    checks++; if (bvalid !== 1'b0)  begin errors++; $display("FAIL reset_bvalid got=%b exp=0", bvalid); end
    checks++; if (rvalid !== 1'b0)  begin errors++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    checks++; if (rdata !== 32'h0)  begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (rd_count !== 0 || wr_count !== 0)
      begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", rd_count, wr_count); end
  endtask

  task automatic test_read_latency();
    logic [31:0] d; int lat; bit ok;
    preload(5, 32'hDEADBEEF);
    axi_read(32'h14, 0, d, lat, ok); exp_rd++;
    checks++; if (lat != RD_LAT) begin errors++; $display("FAIL rd_latency got=%0d exp=%0d", lat, RD_LAT); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", d); end
    checks++; if (rd_count !== exp_rd) begin errors++; $display("FAIL rd_count got=%0d exp=%0d", rd_count, exp_rd); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; int lat; bit ok;
    preload(8, 32'h0);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
    tick(); wvalid = 0;
    checks++; if (wready !== 1'b0 || awready !== 1'b1)
      begin errors++; $display("FAIL w_first_ready got=w%b/aw%b exp=w0/aw1", wready, awready); end
    tick();
    awaddr = 32'h20; awvalid = 1;
    tick(); awvalid = 0;
    lat = 0;
    while (!bvalid && lat < 50) begin tick(); lat++; end
    checks++; if (!bvalid || lat != WR_LAT) begin errors++; $display("FAIL w_first_blat got=%0d exp=%0d", lat, WR_LAT); end
    bready = 1; tick(); bready = 0; exp_wr++;
    model[8] = merge(model[8], 32'h11223344, 4'b0101);
    checks++; if (awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0)
      begin errors++; $display("FAIL w_first_after_b got=aw%b w%b b%b exp=1 1 0", awready, wready, bvalid); end
    checks++; if (wr_count !== exp_wr) begin errors++; $display("FAIL wr_count got=%0d exp=%0d", wr_count, exp_wr); end
    axi_read(32'h20, 0, d, lat, ok); exp_rd++;
    checks++; if (d !== model[8]) begin errors++; $display("FAIL w_first_read got=%h exp=%h", d, model[8]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; int lat; bit ok; int i;
    i = $urandom_range(0, MEM_WORDS - 1);
    preload(i, $urandom);
    axi_read(32'(i) << 2, 5, d, lat, ok); exp_rd++;
    checks++; if (!ok) begin errors++; $display("FAIL bp_hold got=unstable exp=stable"); end
    checks++; if (d !== model[i]) begin errors++; $display("FAIL bp_data got=%h exp=%h", d, model[i]); end
    checks++; if (rd_count !== exp_rd) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", rd_count, exp_rd); end
  endtask

  task automatic test_collision();
    logic [31:0] d; int lat; bit ok;
    preload(16, 32'h1);
    araddr = 32'h40; arvalid = 1; rready = 1;
    tick(); arvalid = 0;
    awaddr = 32'h40; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    tick(); awvalid = 0; wvalid = 0;
    tick();
    checks++; if (rvalid !== 1'b1 || bvalid !== 1'b1)
      begin errors++; $display("FAIL coll_same_edge got=r%b b%b exp=1 1", rvalid, bvalid); end
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL coll_old_value got=%h exp=00000001", rdata); end
    tick(); rready = 0; bready = 0; exp_rd++; exp_wr++;
    model[16] = 32'hCAFEF00D;
    axi_read(32'h40, 0, d, lat, ok); exp_rd++;
    checks++; if (d !== model[16]) begin errors++; $display("FAIL coll_new_value got=%h exp=%h", d, model[16]); end
    checks++; if (rd_count !== exp_rd || wr_count !== exp_wr)
      begin errors++; $display("FAIL coll_counts got=%0d/%0d exp=%0d/%0d", rd_count, wr_count, exp_rd, exp_wr); end
  endtask

  task automatic test_alias();
    logic [31:0] d; int lat; bit ok;
    preload(0, $urandom);
    axi_read(32'h1000, 0, d, lat, ok); exp_rd++;
    checks++; if (d !== model[0]) begin errors++; $display("FAIL alias_read got=%h exp=%h", d, model[0]); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd; logic [3:0] s; int lat, i; bit ok;
    for (int t = 0; t < 40; t++) begin
      i = $urandom_range(0, MEM_WORDS - 1);
      a = {$urandom_range(0, 15) == 0 ? 20'(1) : 20'(0), 10'(i), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 3), lat, ok); exp_wr++;
        model[widx(a)] = merge(model[widx(a)], d, s);
        checks++; if (lat != WR_LAT || !ok)
          begin errors++; $display("FAIL rand_wr_lat t=%0d got=%0d hold=%0b exp=%0d", t, lat, ok, WR_LAT); end
        checks++; if (wr_count !== exp_wr) begin errors++; $display("FAIL rand_wr_count got=%0d exp=%0d", wr_count, exp_wr); end
      end else begin
        axi_read(a, $urandom_range(0, 3), rd, lat, ok); exp_rd++;
        checks++; if (lat != RD_LAT || !ok)
          begin errors++; $display("FAIL rand_rd_lat t=%0d got=%0d hold=%0b exp=%0d", t, lat, ok, RD_LAT); end
        checks++; if (rd !== model[widx(a)])
          begin errors++; $display("FAIL rand_rd_data t=%0d addr=%h got=%h exp=%h", t, a, rd, model[widx(a)]); end
        checks++; if (rd_count !== exp_rd) begin errors++; $display("FAIL rand_rd_count got=%0d exp=%0d", rd_count, exp_rd); end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] v; bit seen_b = 0;
    v = $urandom;
    preload(32, v);
    awaddr = 32'h80; wdata = ~v; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    tick(); awvalid = 0; wvalid = 0;
    resetn = 0;
    #1;
    checks++; if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1)
      begin errors++; $display("FAIL midrst_ready got=%b%b%b exp=111", awready, wready, arready); end
    checks++; if (bvalid !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0)
      begin errors++; $display("FAIL midrst_outputs got=b%b r%b d%h exp=0 0 0", bvalid, rvalid, rdata); end
    checks++; if (rd_count !== 0 || wr_count !== 0)
      begin errors++; $display("FAIL midrst_counts got=%0d/%0d exp=0/0", rd_count, wr_count); end
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    exp_rd = 0; exp_wr = 0;
    repeat (6) begin tick(); if (bvalid) seen_b = 1; end
    bready = 0;
    checks++; if (seen_b) begin errors++; $display("FAIL midrst_no_b got=bvalid exp=none"); end
    checks++; if (dut.u_mem.mem[32] !== v)
      begin errors++; $display("FAIL midrst_word got=%h exp=%h", dut.u_mem.mem[32], v); end
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL midrst_wr_count got=%0d exp=0", wr_count); end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) preload(i, $urandom);
    test_reset();
    test_read_latency();
    test_w_before_aw();
    test_backpressure();
    test_collision();
    test_alias();
    test_random();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/picorv_axil_mem.md
PICORV_AXIL_MEM -- requirements
Module: picorv_axil_mem

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning memory depth in 32-bit words; power of two, 16 to 65536.
REQ-002 SHALL have parameter RD_LATENCY, default 2, meaning cycles from AR handshake to rvalid rising; 1 to 15.
REQ-003 SHALL have parameter WR_LATENCY, default 1, meaning cycles from holding both AW and W to bvalid rising; 1 to 15.
REQ-004 SHALL have port clk  in  1  the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports mem_axi_awvalid in 1, mem_axi_awready out 1, mem_axi_awaddr in 32, mem_axi_awprot in 3 (ignored): write address channel.
REQ-007 SHALL have ports mem_axi_wvalid in 1, mem_axi_wready out 1, mem_axi_wdata in 32, mem_axi_wstrb in 4: write data channel.
REQ-008 SHALL have ports mem_axi_bvalid out 1, mem_axi_bready in 1: write response channel.
REQ-009 SHALL have ports mem_axi_arvalid in 1, mem_axi_arready out 1, mem_axi_araddr in 32, mem_axi_arprot in 3 (ignored): read address channel.
REQ-010 SHALL have ports mem_axi_rvalid out 1, mem_axi_rready in 1, mem_axi_rdata out 32: read data channel.
REQ-011 SHALL have ports rd_count out 32 and wr_count out 32: completed R and B handshakes, wrapping at 2^32.

Function
REQ-012 SHALL be the AXI-Lite slave memory downstream of the picorv32_axi master; ports connect 1:1 to pif.axil_intf_i.
REQ-013 SHALL index words with addr[log2(MEM_WORDS)+1:2]; bits [1:0] ignored; out-of-range addresses alias modulo MEM_WORDS.
REQ-014 Write FSM SHALL have states W_IDLE, W_WAIT, W_RESP.
REQ-015 In W_IDLE, awready SHALL be 1 until AW is captured and wready SHALL be 1 until W is captured; AW and W may arrive in either order or in the same cycle.
REQ-016 Once both are captured, the FSM SHALL go to W_WAIT and count WR_LATENCY-1 cycles; when the count expires it SHALL commit the byte lanes enabled by wstrb and enter W_RESP with bvalid=1.
REQ-017 bvalid SHALL hold until the bvalid&&bready cycle; that cycle increments wr_count and returns to W_IDLE; awready and wready re-assert on the next cycle.
REQ-018 wstrb=0 SHALL complete a normal B handshake with no memory change.
REQ-019 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP; arready=1 only in R_IDLE.
REQ-020 An AR handshake SHALL latch the address; rvalid SHALL rise exactly RD_LATENCY cycles later (RD_LATENCY=1: the next cycle).
REQ-021 rdata SHALL be sampled from the array on entry to R_RESP and held stable while rvalid=1 and rready=0.
REQ-022 The rvalid&&rready cycle SHALL increment rd_count and return to R_IDLE.
REQ-023 Read and write FSMs SHALL run independently and concurrently.
REQ-024 When a write commit and a read sample hit the same word on the same edge, the read SHALL return the pre-write value.
REQ-025 valid/address/data inputs SHALL be ignored while the matching ready is 0.

Reset
REQ-026 Reset SHALL drive awready=1, wready=1, arready=1, bvalid=0, rvalid=0, rdata=0, rd_count=0, wr_count=0.
REQ-027 Reset SHALL put both FSMs in IDLE and clear latency counters and capture flags.
REQ-028 Reset asserted mid-transaction SHALL drop the pending transaction with no array write and no response after release.
REQ-029 Memory contents SHALL NOT be reset; testbench preload is through hierarchical access to the array.

Structure
REQ-030 picorv_pkg SHALL hold AXIL_ADDR_W=32, AXIL_DATA_W=32, AXIL_STRB_W=4 and the enums wr_state_e and rd_state_e.
REQ-031 Storage SHALL be one sub-module picorv_mem_1r1w (one byte-enabled synchronous write port, one synchronous read port); FSMs and counters stay in picorv_axil_mem.

Verification
REQ-032 Preload word 5 with 0xDEADBEEF; AR 0x14 with rready=1 and RD_LATENCY=2 -> rvalid rises 2 cycles after the handshake with rdata=0xDEADBEEF; rd_count=1.
REQ-033 W (0x11223344, wstrb=0b0101) two cycles before AW 0x20, then read 0x20 (prior content 0) -> bvalid after WR_LATENCY, read returns 0x00220044.
REQ-034 Hold rready=0 for 5 cycles after rvalid -> rdata stable, arready=0 throughout, one rd_count increment.
REQ-035 Write 0xCAFEF00D to 0x40 with commit on the same edge as the read sample of 0x40 (old content 0x1) -> read returns 0x1; a later read returns 0xCAFEF00D.
REQ-036 Drop resetn during W_WAIT -> all outputs at reset values asynchronously, no bvalid after release, target word unchanged, wr_count=0.
REQ-037 AR 0x1000 with MEM_WORDS=1024 -> returns word 0 (alias).
